// File: rtl/cards_grid_pos_gen.sv
// Streams row-major {y,x} card positions for a runtime-configured grid over valid/ready.
// Coordinates are built with incremental adders; overflowing rows/columns emit the sentinel.
module cards_grid_pos_gen #(
  parameter int X_W      = 10,
  parameter int Y_W      = 10,
  parameter int MAX_COLS = 8,
  parameter int MAX_ROWS = 8,
  parameter int IDX_W    = 6,
  parameter int CNT_W    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [CNT_W-1:0]     num_cols,
  input  logic [CNT_W-1:0]     num_rows,
  input  logic [X_W-1:0]       x_origin,
  input  logic [Y_W-1:0]       y_origin,
  input  logic [X_W-1:0]       x_pitch,
  input  logic [Y_W-1:0]       y_pitch,
  input  logic                 pos_ready,
  output logic                 pos_valid,
  output logic [Y_W+X_W-1:0]   yx_card_position,
  output logic [IDX_W-1:0]     card_idx,
  output logic                 pos_last,
  output logic                 pos_clip,
  output logic                 busy,
  output logic                 done,
  output logic                 cfg_err
);

  localparam logic [Y_W+X_W-1:0] SENTINEL = '1;
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
  localparam logic [IDX_W-1:0]   IDX_ONE  = IDX_W'(1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] cols_reg, rows_reg, col_reg, row_reg;
  logic [X_W-1:0]   x_org_reg, x_pitch_reg;
  logic [Y_W-1:0]   y_pitch_reg;
  logic [X_W:0]     x_acc_reg;
  logic [Y_W:0]     y_acc_reg;
  logic             x_clip_reg, y_clip_reg;

  logic [X_W+1:0]   x_sum;
  logic [Y_W+1:0]   y_sum;
  logic             x_ovf, y_ovf, col_last;
  logic [CNT_W-1:0] col_next, row_next;
  logic [X_W:0]     x_acc_next;
  logic [Y_W:0]     y_acc_next;
  logic             x_clip_next, y_clip_next, last_next;
  logic [Y_W+X_W-1:0] pos_next, pos_start;
  logic             start_clip, start_last, cfg_ok;

  // Successor of the current card; the wide sums catch carries past the extra accumulator bit.
  always_comb begin
    x_sum       = {1'b0, x_acc_reg} + {2'b00, x_pitch_reg};
    y_sum       = {1'b0, y_acc_reg} + {2'b00, y_pitch_reg};
    x_ovf       = (|x_sum[X_W+1:X_W]) | (&x_sum[X_W-1:0]);
    y_ovf       = (|y_sum[Y_W+1:Y_W]) | (&y_sum[Y_W-1:0]);
    col_last    = (col_reg == cols_reg - CNT_ONE);

    col_next    = col_reg + CNT_ONE;
    row_next    = row_reg;
    x_acc_next  = x_sum[X_W:0];
    x_clip_next = x_clip_reg | x_ovf;
    y_acc_next  = y_acc_reg;
    y_clip_next = y_clip_reg;
    if (col_last) begin
      col_next    = '0;
      row_next    = row_reg + CNT_ONE;
      x_acc_next  = {1'b0, x_org_reg};
      x_clip_next = &x_org_reg;
      y_acc_next  = y_sum[Y_W:0];
      y_clip_next = y_clip_reg | y_ovf;
    end
    last_next = (col_next == cols_reg - CNT_ONE) && (row_next == rows_reg - CNT_ONE);
    pos_next  = (x_clip_next | y_clip_next) ? SENTINEL
                                            : {y_acc_next[Y_W-1:0], x_acc_next[X_W-1:0]};

    start_clip = (&x_origin) | (&y_origin);
    pos_start  = start_clip ? SENTINEL : {y_origin, x_origin};
    start_last = (num_cols == CNT_ONE) && (num_rows == CNT_ONE);
    cfg_ok     = (num_cols != '0) && (num_rows != '0) &&
                 (int'(num_cols) <= MAX_COLS) && (int'(num_rows) <= MAX_ROWS);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= IDLE;
      cols_reg         <= '0;
      rows_reg         <= '0;
      col_reg          <= '0;
      row_reg          <= '0;
      x_org_reg        <= '0;
      x_pitch_reg      <= '0;
      y_pitch_reg      <= '0;
      x_acc_reg        <= '0;
      y_acc_reg        <= '0;
      x_clip_reg       <= 1'b0;
      y_clip_reg       <= 1'b0;
      pos_valid        <= 1'b0;
      yx_card_position <= SENTINEL;
      card_idx         <= '0;
      pos_last         <= 1'b0;
      pos_clip         <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      cfg_err          <= 1'b0;
    end else begin
      done    <= 1'b0;
      cfg_err <= 1'b0;
      if (abort) begin
        state_reg        <= IDLE;
        pos_valid        <= 1'b0;
        yx_card_position <= SENTINEL;
        card_idx         <= '0;
        pos_last         <= 1'b0;
        pos_clip         <= 1'b0;
        busy             <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (start) begin
              if (cfg_ok) begin
                state_reg        <= RUN;
                cols_reg         <= num_cols;
                rows_reg         <= num_rows;
                col_reg          <= '0;
                row_reg          <= '0;
                x_org_reg        <= x_origin;
                x_pitch_reg      <= x_pitch;
                y_pitch_reg      <= y_pitch;
                x_acc_reg        <= {1'b0, x_origin};
                y_acc_reg        <= {1'b0, y_origin};
                x_clip_reg       <= &x_origin;
                y_clip_reg       <= &y_origin;
                pos_valid        <= 1'b1;
                yx_card_position <= pos_start;
                card_idx         <= '0;
                pos_last         <= start_last;
                pos_clip         <= start_clip;
                busy             <= 1'b1;
              end else begin
                cfg_err <= 1'b1;
              end
            end
          end
          RUN: begin
            if (pos_valid && pos_ready) begin
              if (pos_last) begin
                state_reg        <= DONE;
                done             <= 1'b1;
                pos_valid        <= 1'b0;
                yx_card_position <= SENTINEL;
                card_idx         <= '0;
                pos_last         <= 1'b0;
                pos_clip         <= 1'b0;
                busy             <= 1'b0;
              end else begin
                col_reg          <= col_next;
                row_reg          <= row_next;
                x_acc_reg        <= x_acc_next;
                y_acc_reg        <= y_acc_next;
                x_clip_reg       <= x_clip_next;
                y_clip_reg       <= y_clip_next;
                yx_card_position <= pos_next;
                card_idx         <= card_idx + IDX_ONE;
                pos_last         <= last_next;
                pos_clip         <= x_clip_next | y_clip_next;
              end
            end
          end
          DONE:    state_reg <= IDLE;
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cards_grid_pos_gen.sv
// Scoreboard bench for cards_grid_pos_gen: stimulus pushes expected cards, a negedge monitor pops on accept.
module tb_cards_grid_pos_gen;
  localparam int X_W   = 10;
  localparam int Y_W   = 10;
  localparam int IDX_W = 6;
  localparam int CNT_W = 4;
  localparam logic [31:0] SENT = 32'h000F_FFFF;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0, pos_ready = 1'b0;
  logic [CNT_W-1:0] num_cols = '0, num_rows = '0;
  logic [X_W-1:0] x_origin = '0, x_pitch = '0;
  logic [Y_W-1:0] y_origin = '0, y_pitch = '0;
  logic pos_valid, pos_last, pos_clip, busy, done, cfg_err;
  logic [Y_W+X_W-1:0] yx_card_position;
  logic [IDX_W-1:0] card_idx;

  cards_grid_pos_gen dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .num_cols(num_cols), .num_rows(num_rows),
    .x_origin(x_origin), .y_origin(y_origin), .x_pitch(x_pitch), .y_pitch(y_pitch),
    .pos_ready(pos_ready), .pos_valid(pos_valid), .yx_card_position(yx_card_position),
    .card_idx(card_idx), .pos_last(pos_last), .pos_clip(pos_clip),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [Y_W+X_W-1:0] pos;
    logic [IDX_W-1:0]   idx;
    logic               last;
    logic               clip;
  } exp_t;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Monitor: every accepted card (abort overrides accept) is matched against the scoreboard.
  always @(negedge clk) begin
    if (!rst && pos_valid && pos_ready && !abort) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_pos: idx=%0d pos=%h with empty scoreboard", card_idx, yx_card_position);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("accept idx=%0d pos=%h last=%0d clip=%0d", card_idx, yx_card_position, pos_last, pos_clip);
        check("acc_pos",  32'(yx_card_position), 32'(e.pos));
        check("acc_idx",  32'(card_idx), 32'(e.idx));
        check("acc_last", 32'(pos_last), 32'(e.last));
        check("acc_clip", 32'(pos_clip), 32'(e.clip));
      end
    end
  end

  task automatic push_model(input int c, input int r, input int xo, input int yo,
                            input int xp, input int yp);
    for (int ri = 0; ri < r; ri++) begin
      for (int ci = 0; ci < c; ci++) begin
        exp_t e;
        int x, y;
        x = xo + ci * xp;
        y = yo + ri * yp;
        e.clip = (x >= (1 << X_W) - 1) || (y >= (1 << Y_W) - 1);
        e.pos  = e.clip ? '1 : {y[Y_W-1:0], x[X_W-1:0]};
        e.idx  = IDX_W'(ri * c + ci);
        e.last = (ri == r - 1) && (ci == c - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  // Called at posedge+1; returns at the posedge+1 where the started config is first visible.
  task automatic start_sweep(input int c, input int r, input int xo, input int yo,
                             input int xp, input int yp, input bit push);
    num_cols = CNT_W'(c);
    num_rows = CNT_W'(r);
    x_origin = X_W'(xo);
    y_origin = Y_W'(yo);
    x_pitch  = X_W'(xp);
    y_pitch  = Y_W'(yp);
    if (push) push_model(c, r, xo, yo, xp, yp);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idx(input int k, input int limit);
    int n = 0;
    while (card_idx != IDX_W'(k) && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    check("wait_idx", 32'(card_idx), 32'(k));
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    while (!done && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    check("done_pulse", 32'(done), 32'd1);
    check("done_valid_low", 32'(pos_valid), 32'd0);
    check("done_sentinel", 32'(yx_card_position), SENT);
    check("all_accepted", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
    check("done_one_cycle", 32'(done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(pos_valid), 32'd0);
    check("rst_pos", 32'(yx_card_position), SENT);
    check("rst_idx", 32'(card_idx), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_flags", {28'd0, pos_last, pos_clip, done, cfg_err}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 4x2 grid at full throughput, with an ignored start mid-sweep
    pos_ready = 1'b1;
    start_sweep(4, 2, 50, 50, 258, 368, 1'b1);
    check("t1_first_valid", 32'(pos_valid), 32'd1);
    check("t1_first_pos", 32'(yx_card_position), (32'd50 << 10) | 32'd50);
    check("t1_busy", 32'(busy), 32'd1);
    wait_idx(2, 20);
    num_cols = 4'd1;
    x_origin = 10'd0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("t1_start_ignored_busy", 32'(busy), 32'd1);
    wait_done(20);

    // 4x4 grid with a 3-cycle stall on idx5
    start_sweep(4, 4, 50, 25, 258, 175, 1'b1);
    wait_idx(5, 30);
    pos_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("t2_hold_pos", 32'(yx_card_position), (32'd200 << 10) | 32'd308);
      check("t2_hold_idx", 32'(card_idx), 32'd5);
      check("t2_hold_valid", 32'(pos_valid), 32'd1);
      @(posedge clk); #1;
    end
    pos_ready = 1'b1;
    @(posedge clk); #1;
    check("t2_idx6_pos", 32'(yx_card_position), (32'd200 << 10) | 32'd566);
    wait_done(30);

    // rejected configurations
    start_sweep(0, 2, 10, 10, 1, 1, 1'b0);
    check("t3a_cfg_err", 32'(cfg_err), 32'd1);
    check("t3a_valid", 32'(pos_valid), 32'd0);
    check("t3a_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    check("t3a_cfg_err_once", 32'(cfg_err), 32'd0);
    start_sweep(2, 9, 10, 10, 1, 1, 1'b0);
    check("t3b_cfg_err", 32'(cfg_err), 32'd1);
    check("t3b_valid", 32'(pos_valid), 32'd0);
    check("t3b_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    check("t3b_cfg_err_once", 32'(cfg_err), 32'd0);

    // x overflow clipping on a single row
    start_sweep(5, 1, 824, 100, 258, 0, 1'b1);
    wait_done(20);

    // abort at idx2, then a clean restart
    start_sweep(4, 3, 10, 20, 30, 40, 1'b1);
    wait_idx(2, 20);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    exp_q.delete();
    check("t5_abort_valid", 32'(pos_valid), 32'd0);
    check("t5_abort_busy", 32'(busy), 32'd0);
    check("t5_abort_pos", 32'(yx_card_position), SENT);
    for (int i = 0; i < 3; i++) begin
      check("t5_no_done", 32'(done), 32'd0);
      @(posedge clk); #1;
    end
    start_sweep(4, 3, 10, 20, 30, 40, 1'b1);
    check("t5_restart_idx", 32'(card_idx), 32'd0);
    check("t5_restart_pos", 32'(yx_card_position), (32'd20 << 10) | 32'd10);
    wait_done(30);

    // asynchronous reset mid-sweep
    start_sweep(4, 4, 50, 25, 258, 175, 1'b1);
    wait_idx(3, 20);
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_valid", 32'(pos_valid), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_pos", 32'(yx_card_position), SENT);
    check("t6_rst_idx", 32'(card_idx), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("t6_no_pulses", {30'd0, done, cfg_err}, 32'd0);

    // single-card grid: first card is also the last
    start_sweep(1, 1, 5, 6, 0, 0, 1'b1);
    check("t7_last", 32'(pos_last), 32'd1);
    wait_done(10);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/cards_grid_pos_gen.md
Name: cards_grid_pos_gen

Overview:
- Parametrised successor to the fixed-table card position generator. Positions are computed arithmetically from a runtime grid configuration (columns, rows, origin, pitch) instead of hard-coded per difficulty.
- Streams one packed {y,x} position per card to the drawing/hit-test logic over a valid/ready handshake. Each position carries its card index and a last flag.
- Sits between the game-control FSM, which issues start, and the card renderer/card-address logic.

Parameters:
- X_W, 10, width of x coordinate and x fields.
- Y_W, 10, width of y coordinate and y fields.
- MAX_COLS, 8, maximum accepted column count.
- MAX_ROWS, 8, maximum accepted row count.
- IDX_W, 6, card index width; must satisfy 2**IDX_W >= MAX_COLS*MAX_ROWS.
- CNT_W, 4, width of num_cols/num_rows inputs.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a sweep; sampled only in IDLE
- abort  in  1  synchronous cancel, any state
- num_cols  in  CNT_W  grid columns
- num_rows  in  CNT_W  grid rows
- x_origin  in  X_W  x of card 0
- y_origin  in  Y_W  y of card 0
- x_pitch  in  X_W  column step
- y_pitch  in  Y_W  row step
- pos_ready  in  1  consumer accepts current position
- pos_valid  out  1  yx_card_position/card_idx valid
- yx_card_position  out  Y_W+X_W  {y,x}; y in upper field
- card_idx  out  IDX_W  row-major index of current card
- pos_last  out  1  current card is the final one
- pos_clip  out  1  current coordinate overflowed; position is the sentinel
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse after final accept
- cfg_err  out  1  one-cycle pulse on rejected start

Behaviour:
- Reset: all outputs 0 except yx_card_position = all ones (sentinel). State returns to IDLE.
- States: IDLE, RUN, DONE.
- IDLE:
  - Outputs hold the sentinel, pos_valid=0.
  - start=1 with a valid config: latch all config inputs; next cycle enter RUN with pos_valid=1, card_idx=0, position={y_origin,x_origin}. Latency is 1 cycle.
  - Invalid config (num_cols==0, num_rows==0, num_cols>MAX_COLS or num_rows>MAX_ROWS): cfg_err pulses next cycle and state stays IDLE.
- RUN:
  - Inputs are ignored after latching; only the latched copies are used.
  - While pos_valid && !pos_ready, all outputs hold stable.
  - On accept (pos_valid && pos_ready):
    - Column not last: col+1, x += x_pitch, card_idx+1.
    - Column last: col=0, x = x_origin, row+1, y += y_pitch, card_idx+1.
  - pos_valid stays high continuously, giving one position per cycle at full throughput.
  - Incremental adders only; no multipliers.
  - pos_last = (col==cols-1 && row==rows-1).
  - Accept with pos_last=1: go to DONE, pos_valid=0, outputs return to the sentinel.
- DONE: done=1 for exactly one cycle, then IDLE. A start in DONE is ignored.
- Overflow handling:
  - Accumulators are X_W+1 and Y_W+1 bits.
  - A carry into the top bit of a coordinate, or a coordinate equal to the all-ones value, sets a sticky clip for that row or column.
  - A clipped card outputs the sentinel {all ones, all ones} with pos_clip=1 while card_idx still advances.
- abort=1 in any state: next cycle IDLE, pos_valid=0, sentinel output, no done. abort has priority over start and over accept in the same cycle.
- start while busy: ignored, no error.
- Reset mid-sweep: immediate return to reset values, with no done or cfg_err pulse.

Test Plan:
- cols=4, rows=2, origin (50,50), pitch x=258 y=368, pos_ready=1 constantly -> 8 positions: idx0 {50,50}, idx3 {50,824}, idx4 {418,50}, idx7 {418,824} with pos_last=1; done pulses the cycle after idx7 is accepted.
- cols=4, rows=4, origin (50,25), pitch 258/175; pos_ready low for 3 cycles at idx5 -> {200,308} held stable for 3 cycles, then idx6 {200,566}; 16 accepts total.
- cols=0 or rows=9 -> cfg_err pulses once, pos_valid stays 0, busy stays 0.
- cols=5, rows=1, origin x=824, pitch x=258 -> idx0 {y,824}; idx1 through idx4 output the sentinel with pos_clip=1; pos_last is set on idx4.
- abort asserted at idx2 of a 12-card sweep -> pos_valid=0 next cycle, no done; a new start afterwards restarts cleanly from idx0.
- rst asserted asynchronously mid-RUN -> outputs immediately reset values (sentinel, pos_valid=0, busy=0).
